// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control, fetch-address and return-address signals of the PC stage.
// Rev 1.0
`default_nettype none

interface pc_fetch_unit_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
);
  logic              Write_PC;
  logic [1:0]        PC_s;
  logic              cond_ok;
  logic [31:0]       IR;
  logic [31:0]       Rm_data;
  logic [31:0]       PC;
  logic [31:0]       PC_plus4;
  logic [ADDR_W-1:0] Inst_addr;
  logic [31:0]       LR_data;
  logic              Write_LR;
  logic              align_err;
  logic [CNT_W-1:0]  fetch_cnt;

  modport master (
    output Write_PC, PC_s, cond_ok, IR, Rm_data,
    input  PC, PC_plus4, Inst_addr, LR_data, Write_LR, align_err, fetch_cnt
  );

  modport slave (
    input  Write_PC, PC_s, cond_ok, IR, Rm_data,
    output PC, PC_plus4, Inst_addr, LR_data, Write_LR, align_err, fetch_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter with sequential fetch, B/BL/BX redirect, BL link capture.
// Rev 1.0
`default_nettype none

module pc_fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  wire           clk,
  input  wire           Rst,
  pc_fetch_unit_if.slave bus
);

  localparam logic [1:0] SEL_FETCH  = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_BX     = 2'b10;

  logic [31:0]      pc_reg,  pc_nxt;
  logic [31:0]      lr_reg,  lr_nxt;
  logic             wlr_reg, wlr_nxt;
  logic             err_reg, err_nxt;
  logic [CNT_W-1:0] cnt_reg, cnt_nxt;

  logic [31:0] pc_plus4;
  logic [31:0] branch_off;
  logic [31:0] branch_target;
  logic        is_branch;
  logic        is_bl;

  assign pc_plus4      = pc_reg + 32'd4;
  // 24-bit signed word offset, scaled to bytes, relative to branch address + 4
  assign branch_off    = {{6{bus.IR[23]}}, bus.IR[23:0], 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign is_branch     = (bus.IR[27:25] == 3'b101);
  assign is_bl         = is_branch && bus.IR[24];

  always_comb begin
    pc_nxt  = pc_reg;
    lr_nxt  = lr_reg;
    wlr_nxt = 1'b0;
    err_nxt = err_reg;
    cnt_nxt = cnt_reg;
    if (bus.Write_PC) begin
      case (bus.PC_s)
        SEL_FETCH: begin
          pc_nxt = pc_plus4;
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_nxt = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        SEL_BRANCH: begin
          if (is_branch && bus.cond_ok) begin
            pc_nxt = branch_target;
            if (is_bl) begin
              lr_nxt  = pc_reg;
              wlr_nxt = 1'b1;
            end
          end
        end
        SEL_BX: begin
          if (bus.cond_ok) begin
            pc_nxt = bus.Rm_data & ~32'h3;
            if (bus.Rm_data[1:0] != 2'b00) begin
              err_nxt = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      pc_reg  <= RESET_PC;
      lr_reg  <= 32'h0;
      wlr_reg <= 1'b0;
      err_reg <= 1'b0;
      cnt_reg <= '0;
    end else begin
      pc_reg  <= pc_nxt;
      lr_reg  <= lr_nxt;
      wlr_reg <= wlr_nxt;
      err_reg <= err_nxt;
      cnt_reg <= cnt_nxt;
    end
  end

  // ROM addresses alias modulo its depth; upper PC bits are simply dropped
  assign bus.PC        = pc_reg;
  assign bus.PC_plus4  = pc_plus4;
  assign bus.Inst_addr = pc_reg[ADDR_W+1:2];
  assign bus.LR_data   = lr_reg;
  assign bus.Write_LR  = wlr_reg;
  assign bus.align_err = err_reg;
  assign bus.fetch_cnt = cnt_reg;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against an arithmetic model.
// Rev 1.0
`default_nettype none

module tb_pc_fetch_unit;
  localparam int          ADDR_W   = 6;
  localparam int          CNT_W    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_lr;
  logic        m_wlr;
  logic        m_err;
  int          m_cnt;

  pc_fetch_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  pc_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk(clk),
    .Rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RESET_PC;
    m_lr  = 32'h0;
    m_wlr = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_edge(input logic wpc, input logic [1:0] s, input logic c,
                            input logic [31:0] ir, input logic [31:0] rm);
    longint off;
    longint t;
    logic   link;
    link = 1'b0;
    if (wpc) begin
      if (s == 2'd0) begin
        m_pc = m_pc + 32'd4;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else if (s == 2'd1) begin
        if (ir[27:25] == 3'b101 && c) begin
          off = ir[23:0];
          if (off >= 64'h80_0000) off = off - 64'h100_0000;
          if (ir[24]) begin
            m_lr = m_pc;
            link = 1'b1;
          end
          t = m_pc;
          t = t + 4 + off * 4;
          m_pc = t[31:0];
        end
      end else if (s == 2'd2) begin
        if (c) begin
          if (rm % 4 != 0) m_err = 1'b1;
          m_pc = rm - (rm % 4);
        end
      end
    end
    m_wlr = link;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pc"},    bus.PC,        m_pc);
    check({tag, "_pc4"},   bus.PC_plus4,  m_pc + 32'd4);
    check({tag, "_iaddr"}, 32'(bus.Inst_addr), (m_pc / 4) % (1 << ADDR_W));
    check({tag, "_lr"},    bus.LR_data,   m_lr);
    check({tag, "_wlr"},   32'(bus.Write_LR),  32'(m_wlr));
    check({tag, "_err"},   32'(bus.align_err), 32'(m_err));
    check({tag, "_cnt"},   32'(bus.fetch_cnt), 32'(m_cnt));
  endtask

  task automatic step(input string tag, input logic wpc, input logic [1:0] s, input logic c,
                      input logic [31:0] ir, input logic [31:0] rm);
    bus.Write_PC = wpc;
    bus.PC_s     = s;
    bus.cond_ok  = c;
    bus.IR       = ir;
    bus.Rm_data  = rm;
    @(posedge clk);
    model_edge(wpc, s, c, ir, rm);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ir;
    logic [31:0] rm;
    logic [1:0]  s;
    bus.Write_PC = 1'b0;
    bus.PC_s     = 2'b00;
    bus.cond_ok  = 1'b0;
    bus.IR       = 32'h0;
    bus.Rm_data  = 32'h0;
    model_reset();

    do_reset();
    for (int i = 0; i < 5; i++) step("fetch", 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    check("fetch5_pc",    bus.PC, 32'h14);
    check("fetch5_iaddr", 32'(bus.Inst_addr), 32'd5);
    check("fetch5_cnt",   32'(bus.fetch_cnt), 32'd5);
    check("fetch5_wlr",   32'(bus.Write_LR), 32'd0);

    // B +3 from 0x20: target = 0x20 + 4 + 12
    step("bx20", 1'b1, 2'b10, 1'b1, 32'h0, 32'h20);
    step("b_taken", 1'b1, 2'b01, 1'b1, 32'hEA00_0003, 32'h0);
    check("b_taken_pc", bus.PC, 32'h30);
    step("bx20b", 1'b1, 2'b10, 1'b1, 32'h0, 32'h20);
    step("b_nt", 1'b1, 2'b01, 1'b0, 32'hEA00_0003, 32'h0);
    check("b_nt_pc", bus.PC, 32'h20);
    step("b_resv", 1'b1, 2'b01, 1'b1, 32'hE800_0003, 32'h0);
    check("b_resv_pc", bus.PC, 32'h20);

    // BL -2 from 0x40
    step("bx40", 1'b1, 2'b10, 1'b1, 32'h0, 32'h40);
    step("bl", 1'b1, 2'b01, 1'b1, 32'hEBFF_FFFE, 32'h0);
    check("bl_pc",  bus.PC, 32'h3C);
    check("bl_lr",  bus.LR_data, 32'h40);
    check("bl_wlr", 32'(bus.Write_LR), 32'd1);
    step("bl_after", 1'b0, 2'b01, 1'b1, 32'hEBFF_FFFE, 32'h0);
    check("bl_after_wlr", 32'(bus.Write_LR), 32'd0);
    step("s11", 1'b1, 2'b11, 1'b1, 32'hEBFF_FFFE, 32'h0);

    // misaligned BX then aligned BX
    step("bx_mis", 1'b1, 2'b10, 1'b1, 32'h0, 32'h0000_0102);
    check("bx_mis_pc",  bus.PC, 32'h100);
    check("bx_mis_err", 32'(bus.align_err), 32'd1);
    step("bx_al", 1'b1, 2'b10, 1'b1, 32'h0, 32'h80);
    check("bx_al_pc",  bus.PC, 32'h80);
    check("bx_al_err", 32'(bus.align_err), 32'd1);
    step("bx_nc", 1'b1, 2'b10, 1'b0, 32'h0, 32'h44);

    // wraparound
    step("bx_top", 1'b1, 2'b10, 1'b1, 32'h0, 32'hFFFF_FFFC);
    step("wrap", 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    check("wrap_pc",    bus.PC, 32'h0);
    check("wrap_iaddr", 32'(bus.Inst_addr), 32'd0);

    // counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) step("sat", 1'b1, 2'b00, 1'b0, 32'h0, 32'h0);
    check("sat_cnt", 32'(bus.fetch_cnt), 32'hF);

    // async reset right after a taken BL edge
    step("bl2", 1'b1, 2'b01, 1'b1, 32'hEB00_0001, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc",  bus.PC, RESET_PC);
    check("arst_lr",  bus.LR_data, 32'h0);
    check("arst_wlr", 32'(bus.Write_LR), 32'd0);
    check("arst_err", 32'(bus.align_err), 32'd0);
    model_reset();
    bus.Write_PC = 1'b0;
    @(posedge clk);
    #1;
    compare_all("arst_hold");
    @(negedge clk);
    rst = 1'b0;
    step("nowrite", 1'b0, 2'b01, 1'b1, 32'hEB00_0001, 32'h0);
    check("nowrite_pc", bus.PC, RESET_PC);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      ir = $urandom;
      case ($urandom_range(0, 3))
        0: ir[27:24] = 4'hA;
        1: ir[27:24] = 4'hB;
        default: ;
      endcase
      rm = $urandom;
      if ($urandom_range(0, 2) != 0) rm[1:0] = 2'b00;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) s = 2'b00;
      step("rnd", 1'($urandom_range(0, 4) != 0), s, 1'($urandom_range(0, 1)), ir, rm);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
